// File: rtl/lif_timestep_scheduler.sv
// lif_timestep_scheduler: sweeps NUM_NEURONS through one shared LIF datapath.
// Optional: define REFRACTORY_EN for per-neuron refractory skip slots.
module lif_timestep_scheduler #(
    parameter int  NUM_NEURONS   = 4,
    parameter int  V_WIDTH       = 8,
    parameter int  IN_WIDTH      = 5,
    parameter int  REFRAC_CYCLES = 2,
    localparam int IDX_W         = $clog2(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            step_start,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0] ext_in,
    output logic                            busy,
    output logic                            step_done,
    output logic [NUM_NEURONS-1:0]          spikes,
    output logic [7:0]                      spike_count,
    output logic                            dp_req,
    output logic [IDX_W-1:0]                dp_idx,
    output logic [V_WIDTH-1:0]              dp_v,
    output logic [IN_WIDTH-1:0]             dp_cur,
    input  logic                            dp_ack,
    input  logic [V_WIDTH-1:0]              dp_v_next,
    input  logic                            dp_spike
);

    localparam int PC_W = $clog2(NUM_NEURONS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    if (NUM_NEURONS < 2 || NUM_NEURONS > 16 || REFRAC_CYCLES < 1) begin : g_param_check
        $error("lif_timestep_scheduler: parameter out of range");
    end

`ifdef REFRACTORY_EN
    localparam int RC_W = $clog2(REFRAC_CYCLES + 1);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_SKIP, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
`endif

    state_t                 state_q;
    logic                   busy_q;
    logic                   step_done_q;
    logic                   dp_req_q;
    logic [NUM_NEURONS-1:0] spikes_q;
    logic [NUM_NEURONS-1:0] work_q;
    logic [NUM_NEURONS-1:0] work_d;
    logic [7:0]             count_q;
    logic [7:0]             count_d;
    logic [8:0]             count_sum;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_nxt;
    logic [V_WIDTH-1:0]     dp_v_q;
    logic [IN_WIDTH-1:0]    dp_cur_q;
    logic [PC_W-1:0]        pop;
    logic                   last_slot;
    logic                   slot_end;

    logic [V_WIDTH-1:0]     v_q     [NUM_NEURONS];
    logic [IN_WIDTH-1:0]    cur_q   [NUM_NEURONS];
    logic [IN_WIDTH-1:0]    ext_arr [NUM_NEURONS];

`ifdef REFRACTORY_EN
    logic [RC_W-1:0]        rc_q    [NUM_NEURONS];
`endif

    // Slot bookkeeping: unpacked currents, next index, merged spike vector, count.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            ext_arr[i] = ext_in[i*IN_WIDTH +: IN_WIDTH];
        end
        idx_nxt   = idx_q + 1'b1;
        last_slot = (idx_q == LAST_IDX);
        work_d    = work_q;
        if (state_q == S_SWEEP) begin
            work_d[idx_q] = dp_spike;
        end
        pop = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            pop = pop + PC_W'(work_d[i]);
        end
        count_sum = {1'b0, count_q} + 9'(pop);
        count_d   = count_sum[8] ? 8'hFF : count_sum[7:0];
`ifdef REFRACTORY_EN
        slot_end  = (dp_req_q && dp_ack) || (state_q == S_SKIP);
`else
        slot_end  = dp_req_q && dp_ack;
`endif
    end

    // Sequencer: start snapshot, writeback, slot advance, step completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            dp_req_q    <= 1'b0;
            spikes_q    <= '0;
            work_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            dp_v_q      <= '0;
            dp_cur_q    <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]   <= '0;
                cur_q[i] <= '0;
`ifdef REFRACTORY_EN
                rc_q[i]  <= '0;
`endif
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (step_start) begin
                        cur_q    <= ext_arr;
                        idx_q    <= '0;
                        work_q   <= '0;
                        busy_q   <= 1'b1;
                        dp_v_q   <= v_q[0];
                        dp_cur_q <= ext_arr[0];
`ifdef REFRACTORY_EN
                        if (rc_q[0] != '0) begin
                            state_q  <= S_SKIP;
                            dp_req_q <= 1'b0;
                        end else begin
                            state_q  <= S_SWEEP;
                            dp_req_q <= 1'b1;
                        end
`else
                        state_q  <= S_SWEEP;
                        dp_req_q <= 1'b1;
`endif
                    end
                end
                S_SWEEP: begin
                    if (dp_ack) begin
                        v_q[idx_q] <= dp_spike ? '0 : dp_v_next;
                        work_q     <= work_d;
`ifdef REFRACTORY_EN
                        if (dp_spike) begin
                            rc_q[idx_q] <= RC_W'(REFRAC_CYCLES);
                        end
`endif
                    end
                end
`ifdef REFRACTORY_EN
                S_SKIP: begin
                    rc_q[idx_q] <= rc_q[idx_q] - 1'b1;
                end
`endif
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    step_done_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (slot_end) begin
                if (last_slot) begin
                    dp_req_q    <= 1'b0;
                    spikes_q    <= work_d;
                    count_q     <= count_d;
                    step_done_q <= 1'b1;
                    state_q     <= S_DONE;
                end else begin
                    idx_q    <= idx_nxt;
                    dp_v_q   <= v_q[idx_nxt];
                    dp_cur_q <= cur_q[idx_nxt];
`ifdef REFRACTORY_EN
                    if (rc_q[idx_nxt] != '0) begin
                        state_q  <= S_SKIP;
                        dp_req_q <= 1'b0;
                    end else begin
                        state_q  <= S_SWEEP;
                        dp_req_q <= 1'b1;
                    end
`else
                    state_q  <= S_SWEEP;
                    dp_req_q <= 1'b1;
`endif
                end
            end
        end
    end

    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign spikes      = spikes_q;
    assign spike_count = count_q;
    assign dp_req      = dp_req_q;
    assign dp_idx      = idx_q;
    assign dp_v        = dp_v_q;
    assign dp_cur      = dp_cur_q;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// tb_lif_timestep_scheduler: random sweeps scored against a step-level model.
// Build with REFRACTORY_EN defined to exercise the refractory skip slots.
module tb_lif_timestep_scheduler;

    localparam int N   = 4;
    localparam int VW  = 8;
    localparam int IW  = 5;
    localparam int RC  = 2;
    localparam int XW  = $clog2(N);
    localparam int XIW = N * IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step_start = 1'b0;
    logic [XIW-1:0] ext_in = '0;
    logic          busy;
    logic          step_done;
    logic [N-1:0]  spikes;
    logic [7:0]    spike_count;
    logic          dp_req;
    logic [XW-1:0] dp_idx;
    logic [VW-1:0] dp_v;
    logic [IW-1:0] dp_cur;
    logic          dp_ack = 1'b0;
    logic [VW-1:0] dp_v_next = '0;
    logic          dp_spike = 1'b0;

    lif_timestep_scheduler #(
        .NUM_NEURONS  (N),
        .V_WIDTH      (VW),
        .IN_WIDTH     (IW),
        .REFRAC_CYCLES(RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_start (step_start),
        .ext_in     (ext_in),
        .busy       (busy),
        .step_done  (step_done),
        .spikes     (spikes),
        .spike_count(spike_count),
        .dp_req     (dp_req),
        .dp_idx     (dp_idx),
        .dp_v       (dp_v),
        .dp_cur     (dp_cur),
        .dp_ack     (dp_ack),
        .dp_v_next  (dp_v_next),
        .dp_spike   (dp_spike)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] idx;
        logic [VW-1:0] v;
        logic [IW-1:0] cur;
    } iss_t;

    typedef struct packed {
        logic [N-1:0] spk;
        logic [7:0]   cnt;
    } res_t;

    iss_t iss_q[$];
    res_t res_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    int v_m  [N];
    int rc_m [N];
    int cnt_m = 0;

    logic [VW-1:0] tv [N];
    logic          ts [N];

    bit fixed = 1'b0;
    int fdly  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            v_m[i]  = 0;
            rc_m[i] = 0;
        end
        cnt_m = 0;
        iss_q.delete();
        res_q.delete();
    endtask

    // Choose this step's currents and datapath answers, then predict the step.
    task automatic plan_step(input int spk_pct);
        logic [N-1:0] sv;
        int pc;
        int cur [N];
        sv = '0;
        pc = 0;
        for (int i = 0; i < N; i++) begin
            cur[i] = $urandom_range(0, (1 << IW) - 1);
            ext_in[i*IW +: IW] = IW'(cur[i]);
            tv[i] = VW'($urandom);
            ts[i] = ($urandom_range(0, 99) < spk_pct);
        end
        for (int i = 0; i < N; i++) begin
            if (rc_m[i] != 0) begin
                rc_m[i]--;
            end else begin
                iss_q.push_back('{XW'(i), VW'(v_m[i]), IW'(cur[i])});
                if (ts[i]) begin
                    sv[i] = 1'b1;
                    pc++;
                    v_m[i] = 0;
`ifdef REFRACTORY_EN
                    rc_m[i] = RC;
`endif
                end else begin
                    v_m[i] = int'(tv[i]);
                end
            end
        end
        cnt_m = (cnt_m + pc > 255) ? 255 : cnt_m + pc;
        res_q.push_back('{sv, 8'(cnt_m)});
    endtask

    // Run one full step; n returns the cycle (edge 0 = 1) where step_done shows.
    task automatic run_step(input int spk_pct, input int hold, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        plan_step(spk_pct);
        step_start = 1'b1;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) ext_in = XIW'($urandom);
            if (c >= hold) step_start = 1'b0;
            if (step_done) begin
                seen = 1'b1;
                n = c;
            end
        end
        step_start = 1'b0;
        if (!seen) begin
            n_chk++;
            $display("FAIL step_timeout: no step_done within 200 cycles");
        end else begin
            chk("busy_in_done", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            chk("idle_after_done", {30'd0, busy, step_done}, 32'd0);
        end
    endtask

    // Shared-datapath stand-in: answers requests after a delay, noise otherwise.
    initial begin
        int wcnt;
        wcnt = -1;
        forever begin
            @(posedge clk);
            #1;
            if (dp_req) begin
                if (wcnt < 0) wcnt = fixed ? fdly : $urandom_range(0, 3);
                if (wcnt == 0) begin
                    dp_ack    = 1'b1;
                    dp_v_next = tv[dp_idx];
                    dp_spike  = ts[dp_idx];
                    wcnt      = -1;
                end else begin
                    dp_ack    = 1'b0;
                    dp_v_next = VW'($urandom);
                    dp_spike  = 1'($urandom);
                    wcnt--;
                end
            end else begin
                dp_ack    = 1'($urandom);
                dp_v_next = VW'($urandom);
                dp_spike  = 1'($urandom);
                wcnt      = -1;
            end
        end
    end

    // Monitor: request fields against the issue queue, results against the step queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_req) begin
                if (iss_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_req: idx=%0d with nothing expected", dp_idx);
                end else begin
                    chk("dp_idx", 32'(dp_idx), 32'(iss_q[0].idx));
                    chk("dp_v", 32'(dp_v), 32'(iss_q[0].v));
                    chk("dp_cur", 32'(dp_cur), 32'(iss_q[0].cur));
                    if (dp_ack) void'(iss_q.pop_front());
                end
            end
            if (step_done) begin
                if (res_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: spikes=%0h with nothing expected", spikes);
                end else begin
                    chk("spikes", 32'(spikes), 32'(res_q[0].spk));
                    chk("spike_count", 32'(spike_count), 32'(res_q[0].cnt));
                    void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(step_done), 32'd0);
        chk("rst_spikes", 32'(spikes), 32'd0);
        chk("rst_count", 32'(spike_count), 32'd0);
        chk("rst_req", 32'(dp_req), 32'd0);
        chk("rst_v", 32'(dp_v), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fixed = 1'b1;
        fdly  = 0;
        run_step(0, 1, n);
        chk("latency_ack_tied", 32'(n), 32'(N + 1));
        fdly = 2;
        run_step(0, 1, n);
        chk("latency_ack_delayed", 32'(n), 32'(3 * N + 1));
        fixed = 1'b0;

        for (int s = 0; s < 60; s++) begin
            run_step(30, $urandom_range(1, 3), n);
        end

        plan_step(50);
        step_start = 1'b1;
        @(posedge clk);
        #1;
        step_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(dp_req), 32'd0);
        chk("midrst_spikes", 32'(spikes), 32'd0);
        chk("midrst_count", 32'(spike_count), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(step_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < 40; s++) begin
            run_step(40, $urandom_range(1, 3), n);
        end
        for (int s = 0; s < 80; s++) begin
            run_step(100, $urandom_range(1, 3), n);
        end
        chk("count_final", 32'(spike_count), 32'(cnt_m));
`ifndef REFRACTORY_EN
        chk("count_saturated", 32'(spike_count), 32'd255);
`endif
        chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
        chk("result_queue_drained", 32'(res_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
